sensor_request_master: RTL and testbench

//  Host/initiator end of the UART sensor protocol. On request it sends the address byte and then
//  the command byte over the UART TX. It then collects the 3-byte response (command, integral,

---
 rtl/sensor_request_master_pkg.sv | 42 ++++
 rtl/timeout_timer.sv | 29 ++
 rtl/sensor_request_master.sv | 149 ++++++++++++++
 tb/tb_sensor_request_master.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_request_master_pkg.sv
// Shared protocol definitions for the UART sensor link: request/response
// codes, the request->response mapping and the master FSM state type.
package sensor_request_master_pkg;

   localparam logic [7:0] REQ_STATUS = 8'h03;
   localparam logic [7:0] REQ_TEMP   = 8'h04;
   localparam logic [7:0] REQ_HUMID  = 8'h05;

   localparam logic [7:0] RSP_STATUS = 8'h00;
   localparam logic [7:0] RSP_HUMID  = 8'h01;
   localparam logic [7:0] RSP_TEMP   = 8'h02;
   localparam logic [7:0] RSP_FAULT  = 8'h1f;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_TX_ADDR,
      ST_WAIT_ADDR,
      ST_TX_CMD,
      ST_WAIT_CMD,
      ST_RX_CMD,
      ST_RX_INT,
      ST_RX_DEC,
      ST_DONE
   } state_t;

   function automatic logic req_valid(input logic [7:0] code);
      return (code == REQ_STATUS) || (code == REQ_TEMP) || (code == REQ_HUMID);
   endfunction

   // Response code a healthy responder returns for a given request.
   function automatic logic [7:0] expected_rsp(input logic [7:0] code);
      logic [7:0] rsp;
      case (code)
         REQ_STATUS: rsp = RSP_STATUS;
         REQ_TEMP:   rsp = RSP_TEMP;
         REQ_HUMID:  rsp = RSP_HUMID;
         default:    rsp = RSP_FAULT;
      endcase
      return rsp;
   endfunction

endpackage

// File: rtl/timeout_timer.sv
// Idle-cycle watchdog: counts while enabled, clears on request, saturates
// instead of wrapping, and flags the last allowed cycle.
module timeout_timer #(
   parameter int TIMEOUT_CYCLES = 50_000_000
) (
   input  logic i_Clock,
   input  logic i_Reset,
   input  logic i_Clear,
   input  logic i_Enable,
   output logic o_Expired
);

   localparam int W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);
   localparam logic [W-1:0] SAT  = W'(TIMEOUT_CYCLES);

   logic [W-1:0] count;

   // Count enabled cycles since the last clear, holding at SAT.
   always_ff @(posedge i_Clock) begin
      if (i_Reset || i_Clear)
         count <= '0;
      else if (i_Enable && (count != SAT))
         count <= count + 1'b1;
   end

   assign o_Expired = (count >= LAST);

endmodule

// File: rtl/sensor_request_master.sv
// Initiator side of the UART sensor protocol: sends address + command,
// collects the 3-byte reply and reports result/status to the host.
module sensor_request_master
   import sensor_request_master_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50_000_000
) (
   input  logic       i_Clock,
   input  logic       i_Reset,
   input  logic       i_Req_Start,
   input  logic [7:0] i_Req_Address,
   input  logic [7:0] i_Req_Command,
   input  logic       i_Tx_Done,
   input  logic [7:0] i_Rx_Data,
   input  logic       i_Rx_Done,
   output logic [7:0] o_Tx_Data,
   output logic       o_Tx_Start,
   output logic       o_Busy,
   output logic       o_Done,
   output logic [7:0] o_Rsp_Command,
   output logic [7:0] o_Rsp_Integral,
   output logic [7:0] o_Rsp_Decimal,
   output logic       o_Timeout,
   output logic       o_Error,
   output logic       o_Dth_Fault
);

   state_t     state, state_next;
   logic [7:0] req_cmd;
   logic       rx_vld;
   logic [7:0] rx_byte;
   logic       in_rx, in_wait;
   logic       step;
   logic       accept;
   logic       tmr_clr, tmr_exp;
   logic       timeout_hit;

   assign in_rx   = (state == ST_RX_CMD) || (state == ST_RX_INT) || (state == ST_RX_DEC);
   assign in_wait = (state == ST_WAIT_ADDR) || (state == ST_WAIT_CMD);
   // The o_Done cycle is still "finishing": a start there is dropped, not queued.
   assign accept  = (state == ST_IDLE) && i_Req_Start && !o_Done;
   assign tmr_clr = (state_next != state);
   // An event in the expiry cycle wins over the timeout.
   assign timeout_hit = (in_wait || in_rx) && tmr_exp && !step;
   assign o_Tx_Start  = (state == ST_TX_ADDR) || (state == ST_TX_CMD);

   timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
      .i_Clock   (i_Clock),
      .i_Reset   (i_Reset),
      .i_Clear   (tmr_clr),
      .i_Enable  (in_wait || in_rx),
      .o_Expired (tmr_exp)
   );

   // Progress event of the current wait: tx-done in WAIT_*, a received byte in RX_*.
   always_comb begin
      step = 1'b0;
      if (in_wait)
         step = i_Tx_Done;
      else if (in_rx)
         step = rx_vld;
   end

   // State register.
   always_ff @(posedge i_Clock) begin
      if (i_Reset)
         state <= ST_IDLE;
      else
         state <= state_next;
   end

   // Next-state logic; a timeout overrides any wait state.
   always_comb begin
      state_next = state;
      unique case (state)
         ST_IDLE:      if (accept) state_next = req_valid(i_Req_Command) ? ST_TX_ADDR : ST_DONE;
         ST_TX_ADDR:   state_next = ST_WAIT_ADDR;
         ST_WAIT_ADDR: if (step) state_next = ST_TX_CMD;
         ST_TX_CMD:    state_next = ST_WAIT_CMD;
         ST_WAIT_CMD:  if (step) state_next = ST_RX_CMD;
         ST_RX_CMD:    if (step) state_next = ST_RX_INT;
         ST_RX_INT:    if (step) state_next = ST_RX_DEC;
         ST_RX_DEC:    if (step) state_next = ST_DONE;
         ST_DONE:      state_next = ST_IDLE;
         default:      state_next = ST_IDLE;
      endcase
      if (timeout_hit)
         state_next = ST_DONE;
   end

   // Datapath: request latch, tx byte, registered rx input, response and status registers.
   // uart_rx is registered once before the FSM sees it; bytes arriving outside RX_* are dropped here.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         req_cmd        <= '0;
         rx_vld         <= 1'b0;
         rx_byte        <= '0;
         o_Tx_Data      <= '0;
         o_Busy         <= 1'b0;
         o_Done         <= 1'b0;
         o_Rsp_Command  <= '0;
         o_Rsp_Integral <= '0;
         o_Rsp_Decimal  <= '0;
         o_Timeout      <= 1'b0;
         o_Error        <= 1'b0;
         o_Dth_Fault    <= 1'b0;
      end else begin
         rx_vld  <= i_Rx_Done && in_rx;
         rx_byte <= i_Rx_Data;
         o_Done  <= (state == ST_DONE);
         if (state == ST_DONE)
            o_Busy <= 1'b0;
         if (timeout_hit)
            o_Timeout <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  req_cmd     <= i_Req_Command;
                  o_Timeout   <= 1'b0;
                  o_Dth_Fault <= 1'b0;
                  if (req_valid(i_Req_Command)) begin
                     o_Busy         <= 1'b1;
                     o_Error        <= 1'b0;
                     o_Tx_Data      <= i_Req_Address;
                     o_Rsp_Command  <= '0;
                     o_Rsp_Integral <= '0;
                     o_Rsp_Decimal  <= '0;
                  end else begin
                     o_Error <= 1'b1;
                  end
               end
            end
            ST_WAIT_ADDR: if (step) o_Tx_Data <= req_cmd;
            ST_RX_CMD:    if (step) o_Rsp_Command <= rx_byte;
            ST_RX_INT:    if (step) o_Rsp_Integral <= rx_byte;
            ST_RX_DEC: begin
               if (step) begin
                  o_Rsp_Decimal <= rx_byte;
                  o_Dth_Fault   <= (o_Rsp_Command == RSP_FAULT);
                  o_Error       <= (o_Rsp_Command != expected_rsp(req_cmd)) &&
                                   (o_Rsp_Command != RSP_FAULT);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sensor_request_master.sv
// Bench for sensor_request_master: directed scenarios plus randomized
// transactions against a behavioural UART/responder and result model.
module tb_sensor_request_master;

   localparam int TO = 100;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_start;
   logic [7:0] req_addr, req_cmd;
   logic       tx_done;
   logic [7:0] rx_data;
   logic       rx_done;
   logic [7:0] tx_data;
   logic       tx_start, busy, done;
   logic [7:0] rsp_cmd, rsp_int, rsp_dec;
   logic       tmo, err, dth;

   always #5 clk = ~clk;

   sensor_request_master #(.TIMEOUT_CYCLES(TO)) dut (
      .i_Clock        (clk),
      .i_Reset        (rst),
      .i_Req_Start    (req_start),
      .i_Req_Address  (req_addr),
      .i_Req_Command  (req_cmd),
      .i_Tx_Done      (tx_done),
      .i_Rx_Data      (rx_data),
      .i_Rx_Done      (rx_done),
      .o_Tx_Data      (tx_data),
      .o_Tx_Start     (tx_start),
      .o_Busy         (busy),
      .o_Done         (done),
      .o_Rsp_Command  (rsp_cmd),
      .o_Rsp_Integral (rsp_int),
      .o_Rsp_Decimal  (rsp_dec),
      .o_Timeout      (tmo),
      .o_Error        (err),
      .o_Dth_Fault    (dth)
   );

   int         cyc = 0;
   int         n_asrt = 0;
   int         n_fail = 0;
   bit         tx_due;
   logic [7:0] txq[$];
   int         cmd_tx_cyc;
   bit         done_seen;
   int         done_cyc;
   logic       done_busy;
   int         req_cyc;
   int         last_rx;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference rules: valid requests and the response code each expects.
   function automatic bit code_ok(input logic [7:0] c);
      return (c == 8'h03) || (c == 8'h04) || (c == 8'h05);
   endfunction

   function automatic logic [7:0] exp_code(input logic [7:0] c);
      if (c == 8'h03) return 8'h00;
      if (c == 8'h04) return 8'h02;
      return 8'h01;
   endfunction

   // One clock: sample outputs after the edge, run the ideal uart_tx model
   // (tx-done one cycle after each start) and record o_Done.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      req_start = 1'b0;
      rx_done   = 1'b0;
      tx_done   = tx_due;
      tx_due    = 1'b0;
      if (tx_done && txq.size() == 2 && cmd_tx_cyc < 0) cmd_tx_cyc = cyc;
      if (tx_start) begin
         txq.push_back(tx_data);
         tx_due = 1'b1;
      end
      if (done) begin
         done_seen = 1'b1;
         done_cyc  = cyc;
         done_busy = busy;
      end
   endtask

   task automatic begin_txn();
      txq.delete();
      done_seen  = 1'b0;
      done_cyc   = -1;
      cmd_tx_cyc = -1;
   endtask

   task automatic start_req(input logic [7:0] a, input logic [7:0] c);
      req_addr  = a;
      req_cmd   = c;
      req_start = 1'b1;
      req_cyc   = cyc;
      tick();
   endtask

   task automatic wait_cmd_tx();
      int k = 0;
      while (cmd_tx_cyc < 0 && k < 50) begin tick(); k++; end
      chk("cmd_tx_seen", cmd_tx_cyc >= 0, 1'b1);
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_done = 1'b1;
      rx_data = b;
      last_rx = cyc;
      tick();
   endtask

   task automatic wait_done(input int budget);
      int k = 0;
      while (!done_seen && k < budget) begin tick(); k++; end
      chk("done_seen", done_seen, 1'b1);
   endtask

   // Expected outcome from the request, the reply bytes and how many of them arrived.
   task automatic check_result(input string tag, input logic [7:0] a, input logic [7:0] c,
                               input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                               input int nrx, input int exp_done);
      chk({tag, " done_cyc"}, done_cyc, exp_done);
      chk({tag, " busy_at_done"}, done_busy, 1'b0);
      if (!code_ok(c)) begin
         chk({tag, " tx_count"}, txq.size(), 0);
         chk({tag, " error"}, err, 1'b1);
         chk({tag, " timeout"}, tmo, 1'b0);
         chk({tag, " dth"}, dth, 1'b0);
      end else begin
         chk({tag, " tx_count"}, txq.size(), 2);
         if (txq.size() == 2) begin
            chk({tag, " tx_addr"}, txq[0], a);
            chk({tag, " tx_cmd"}, txq[1], c);
         end
         chk({tag, " rsp_cmd"}, rsp_cmd, (nrx >= 1) ? b0 : 8'h00);
         chk({tag, " rsp_int"}, rsp_int, (nrx >= 2) ? b1 : 8'h00);
         chk({tag, " rsp_dec"}, rsp_dec, (nrx >= 3) ? b2 : 8'h00);
         chk({tag, " timeout"}, tmo, nrx < 3);
         chk({tag, " dth"}, dth, (nrx == 3) && (b0 == 8'h1f));
         chk({tag, " error"}, err, (nrx == 3) && !((b0 == exp_code(c)) || (b0 == 8'h1f)));
      end
   endtask

   // Complete transaction with an ideal responder; gap = idle cycles before/between bytes.
   task automatic full_txn(input string tag, input logic [7:0] a, input logic [7:0] c,
                           input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input int gap);
      begin_txn();
      start_req(a, c);
      if (code_ok(c)) begin
         chk({tag, " busy"}, busy, 1'b1);
         wait_cmd_tx();
         tick();
         repeat (gap) tick();
         send_byte(b0);
         repeat (gap) tick();
         send_byte(b1);
         send_byte(b2);
         wait_done(20);
         check_result(tag, a, c, b0, b1, b2, 3, last_rx + 3);
      end else begin
         chk({tag, " busy"}, busy, 1'b0);
         wait_done(10);
         check_result(tag, a, c, 8'h00, 8'h00, 8'h00, 0, req_cyc + 2);
      end
   endtask

   initial begin
      int w;
      logic [7:0] a, c, b0, b1, b2;
      rst = 1'b1; req_start = 1'b0; req_addr = '0; req_cmd = '0;
      tx_done = 1'b0; rx_data = '0; rx_done = 1'b0; tx_due = 1'b0;
      begin_txn();
      repeat (3) tick();
      rst = 1'b0;
      chk("reset_outputs", {tx_data, tx_start, busy, done, rsp_cmd, rsp_int, rsp_dec, tmo, err, dth}, '0);

      // 1..4: directed basics
      full_txn("t1_temp", 8'h00, 8'h04, 8'h02, 8'h1a, 8'h05, 0);
      tick();
      full_txn("t2_fault", 8'h12, 8'h05, 8'h1f, 8'h00, 8'h00, 0);
      tick();
      full_txn("t3_mismatch", 8'h34, 8'h03, 8'h02, 8'h00, 8'h00, 1);
      tick();
      full_txn("t4_invalid", 8'h56, 8'h07, 8'h00, 8'h00, 8'h00, 0);
      tick();

      // 5a: silent responder times out
      begin_txn(); start_req(8'h07, 8'h04); wait_cmd_tx(); w = cmd_tx_cyc;
      wait_done(TO + 20);
      check_result("t5a_silent", 8'h07, 8'h04, 8'h00, 8'h00, 8'h00, 0, w + TO + 2);
      tick();
      // 5b: byte landing on the expiry cycle wins
      begin_txn(); start_req(8'h08, 8'h04); wait_cmd_tx(); w = cmd_tx_cyc;
      while (cyc < w + TO - 1) tick();
      send_byte(8'h02); send_byte(8'h1a); send_byte(8'h05);
      wait_done(20);
      check_result("t5b_edge_win", 8'h08, 8'h04, 8'h02, 8'h1a, 8'h05, 3, last_rx + 3);
      tick();
      // 5c: one cycle later is too late
      begin_txn(); start_req(8'h09, 8'h04); wait_cmd_tx(); w = cmd_tx_cyc;
      while (cyc < w + TO) tick();
      send_byte(8'h02);
      wait_done(20);
      check_result("t5c_edge_late", 8'h09, 8'h04, 8'h00, 8'h00, 8'h00, 0, w + TO + 2);
      tick();

      // Start while busy is ignored; start in the o_Done cycle is ignored.
      begin_txn(); start_req(8'h11, 8'h05); wait_cmd_tx(); tick();
      start_req(8'h22, 8'h03);
      send_byte(8'h01); send_byte(8'h33); send_byte(8'h44);
      wait_done(20);
      check_result("busy_ignore", 8'h11, 8'h05, 8'h01, 8'h33, 8'h44, 3, last_rx + 3);
      begin_txn(); start_req(8'h22, 8'h04);
      repeat (5) tick();
      chk("done_cycle_start_tx", txq.size(), 0);
      chk("done_cycle_start_busy", busy, 1'b0);

      // Stray byte in IDLE is ignored.
      send_byte(8'h5a);
      repeat (3) tick();
      chk("stray_no_done", done_seen, 1'b0);
      chk("stray_rsp_held", rsp_cmd, 8'h01);
      full_txn("after_stray", 8'h23, 8'h03, 8'h00, 8'h00, 8'h00, 0);
      tick();

      // 6: reset during RX_INT aborts silently.
      begin_txn(); start_req(8'h01, 8'h04); wait_cmd_tx(); tick();
      send_byte(8'h02);
      tick();
      chk("pre_reset_rsp", rsp_cmd, 8'h02);
      rst = 1'b1;
      tick();
      rst = 1'b0; tx_due = 1'b0;
      chk("mid_reset_outputs", {tx_data, tx_start, busy, done, rsp_cmd, rsp_int, rsp_dec, tmo, err, dth}, '0);
      repeat (8) tick();
      chk("mid_reset_no_done", done_seen, 1'b0);

      // Randomized transactions against the reference rules.
      for (int i = 0; i < 16; i++) begin
         a = 8'($urandom);
         if ($urandom_range(0, 5) == 0) c = 8'(6 + $urandom_range(0, 240));
         else c = 8'(3 + $urandom_range(0, 2));
         case ($urandom_range(0, 3))
            0: b0 = exp_code(c);
            1: b0 = 8'h1f;
            default: b0 = 8'($urandom_range(0, 2));
         endcase
         b1 = 8'($urandom);
         b2 = 8'($urandom);
         full_txn("rnd", a, c, b0, b1, b2, $urandom_range(0, 6));
         repeat (1 + $urandom_range(0, 3)) tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
